// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction-fetch port and a data port onto a
// single memory port. Data has priority, and a starvation counter forces a
// fetch grant after STARVE_MAX consecutive data grants that were made while a
// fetch was waiting. All outputs are registered.
// Optional feature: define ARB_TIMEOUT_EN to add a memory-ack timeout that
// completes the transaction with zero data and pulses err_o.
module mem_arbiter #(
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_i,
  input  logic [DW-1:0] if_addr_i,
  output logic          if_gnt_o,
  output logic          if_valid_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [DW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  input  logic [3:0]    d_be_i,
  output logic          d_gnt_o,
  output logic          d_valid_o,
  output logic [DW-1:0] d_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [DW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic [3:0]    mem_be_o,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          err_o
);

  localparam int unsigned   SW         = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          fetch_wins;

  logic          if_gnt_q, if_gnt_d;
  logic          if_valid_q, if_valid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic          d_gnt_q, d_gnt_d;
  logic          d_valid_q, d_valid_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_be_q, mem_be_d;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned   TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          err_q, err_d;
`endif

  // Next-state, arbitration and registered-output computation.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    fetch_wins  = if_req_i && (!d_req_i || (starve_q == STARVE_LIM));
`ifdef ARB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
    err_d       = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef ARB_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
        if (fetch_wins) begin
          state_d     = BUSY_I;
          starve_d    = '0;
          if_gnt_d    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr_i;
          mem_wdata_d = '0;
          mem_be_d    = 4'hF;
        end else if (d_req_i) begin
          state_d     = BUSY_D;
          d_gnt_d     = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we_i;
          mem_addr_d  = d_addr_i;
          mem_wdata_d = d_wdata_i;
          mem_be_d    = d_be_i;
          if (if_req_i && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + SW'(1);
          end
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ack_i) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          if (state_q == BUSY_I) begin
            if_valid_d = 1'b1;
            if_rdata_d = mem_rdata_i;
          end else begin
            d_valid_d = 1'b1;
            d_rdata_d = mem_rdata_i;
          end
        end
`ifdef ARB_TIMEOUT_EN
        else if (tmo_cnt_q == TO_LAST) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          err_d     = 1'b1;
          if (state_q == BUSY_I) begin
            if_valid_d = 1'b1;
            if_rdata_d = '0;
          end else begin
            d_valid_d = 1'b1;
            d_rdata_d = '0;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      if_gnt_q    <= 1'b0;
      if_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_gnt_q     <= 1'b0;
      d_valid_q   <= 1'b0;
      d_rdata_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      if_gnt_q    <= if_gnt_d;
      if_valid_q  <= if_valid_d;
      if_rdata_q  <= if_rdata_d;
      d_gnt_q     <= d_gnt_d;
      d_valid_q   <= d_valid_d;
      d_rdata_q   <= d_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Ack-timeout counter and error pulse register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign if_gnt_o    = if_gnt_q;
  assign if_valid_o  = if_valid_q;
  assign if_rdata_o  = if_rdata_q;
  assign d_gnt_o     = d_gnt_q;
  assign d_valid_o   = d_valid_q;
  assign d_rdata_o   = d_rdata_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_be_o    = mem_be_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run checked against a
// transaction-level reference model of the arbiter.
module tb_mem_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned SM = 4;
  localparam int unsigned TO = 16;
  localparam int unsigned VW = 4*DW + 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i, if_gnt_o, if_valid_o;
  logic [DW-1:0] if_addr_i, if_rdata_o;
  logic          d_req_i, d_we_i, d_gnt_o, d_valid_o;
  logic [DW-1:0] d_addr_i, d_wdata_i, d_rdata_o;
  logic [3:0]    d_be_i, mem_be_o;
  logic          mem_req_o, mem_we_o, mem_ack_i, err_o;
  logic [DW-1:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int            m_owner, m_starve, m_elapsed;
  logic          e_if_gnt, e_d_gnt, e_if_valid, e_d_valid, e_mem_req, e_mem_we, e_err;
  logic [DW-1:0] e_if_rdata, e_d_rdata, e_mem_addr, e_mem_wdata;
  logic [3:0]    e_mem_be;

  logic [VW-1:0] dut_vec;
  assign dut_vec = {if_gnt_o, d_gnt_o, if_valid_o, d_valid_o, if_rdata_o, d_rdata_o,
                    mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, err_o};

  always #5 clk = ~clk;

  mem_arbiter #(.DW(DW), .STARVE_MAX(SM), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_be_i(d_be_i), .d_gnt_o(d_gnt_o), .d_valid_o(d_valid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    if_req_i = 0; if_addr_i = '0; d_req_i = 0; d_we_i = 0; d_addr_i = '0;
    d_wdata_i = '0; d_be_i = '0; mem_ack_i = 0; mem_rdata_i = '0;
  endtask

  task automatic do_reset();
    rst = 0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    clear_inputs();
    #1;
    n_cmp++;
    if (dut_vec !== '0) begin n_bad++; $display("FAIL reset_async got %h want 0", dut_vec); end
    tick();
    if_req_i = 1; d_req_i = 1; mem_ack_i = 1;
    tick();
    n_cmp++;
    if (dut_vec !== '0) begin n_bad++; $display("FAIL reset_hold got %h want 0", dut_vec); end
    clear_inputs();
    rst = 1;
    tick();
    n_cmp++;
    if (dut_vec !== '0) begin n_bad++; $display("FAIL reset_release_idle got %h want 0", dut_vec); end
  endtask

  task automatic test_single_fetch();
    do_reset();
    if_req_i = 1; if_addr_i = 32'h10;
    tick();
    n_cmp++;
    if ({if_gnt_o, d_gnt_o, mem_req_o, mem_we_o, mem_be_o} !== 8'b1010_1111) begin
      n_bad++; $display("FAIL fetch_gnt got %b want 10101111", {if_gnt_o, d_gnt_o, mem_req_o, mem_we_o, mem_be_o});
    end
    n_cmp++;
    if (mem_addr_o !== 32'h10 || mem_wdata_o !== 32'h0) begin
      n_bad++; $display("FAIL fetch_mem got addr %h wdata %h want 10 / 0", mem_addr_o, mem_wdata_o);
    end
    if_req_i = 0; mem_ack_i = 1; mem_rdata_i = 32'h0050_0093;
    tick();
    mem_ack_i = 0; mem_rdata_i = 32'hFFFF_FFFF;
    n_cmp++;
    if ({if_valid_o, if_gnt_o, mem_req_o, if_rdata_o} !== {3'b100, 32'h0050_0093}) begin
      n_bad++; $display("FAIL fetch_valid got v%b g%b r%b d%h want v1 g0 r0 d00500093", if_valid_o, if_gnt_o, mem_req_o, if_rdata_o);
    end
    tick();
    n_cmp++;
    if (if_valid_o !== 1'b0 || if_rdata_o !== 32'h0050_0093) begin
      n_bad++; $display("FAIL fetch_hold got v%b d%h want v0 d00500093", if_valid_o, if_rdata_o);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    if_req_i = 1; if_addr_i = 32'h40; d_req_i = 1; d_addr_i = 32'h200;
    tick();
    n_cmp++;
    if ({if_gnt_o, d_gnt_o} !== 2'b01 || mem_addr_o !== 32'h200) begin
      n_bad++; $display("FAIL simul_first got gnt %b addr %h want 01 / 200", {if_gnt_o, d_gnt_o}, mem_addr_o);
    end
    d_req_i = 0; mem_ack_i = 1; mem_rdata_i = 32'hAAAA_0001;
    tick();
    mem_ack_i = 0;
    n_cmp++;
    if ({d_valid_o, if_valid_o} !== 2'b10 || d_rdata_o !== 32'hAAAA_0001) begin
      n_bad++; $display("FAIL simul_dvalid got %b %h want 10 aaaa0001", {d_valid_o, if_valid_o}, d_rdata_o);
    end
    tick();
    n_cmp++;
    if ({if_gnt_o, d_gnt_o} !== 2'b10 || mem_addr_o !== 32'h40) begin
      n_bad++; $display("FAIL simul_second got gnt %b addr %h want 10 / 40", {if_gnt_o, d_gnt_o}, mem_addr_o);
    end
    if_req_i = 0; mem_ack_i = 1; mem_rdata_i = 32'h5555_0002;
    tick();
    mem_ack_i = 0;
    n_cmp++;
    if (if_valid_o !== 1'b1 || if_rdata_o !== 32'h5555_0002 || d_rdata_o !== 32'hAAAA_0001) begin
      n_bad++; $display("FAIL simul_ivalid got v%b i%h d%h want v1 i55550002 daaaa0001", if_valid_o, if_rdata_o, d_rdata_o);
    end
  endtask

  task automatic test_write();
    do_reset();
    mem_ack_i = 1; mem_rdata_i = 32'h1111_1111;
    tick();
    n_cmp++;
    if ({if_valid_o, d_valid_o, mem_req_o} !== 3'b000 || d_rdata_o !== '0) begin
      n_bad++; $display("FAIL idle_ack got %b %h want 000 0", {if_valid_o, d_valid_o, mem_req_o}, d_rdata_o);
    end
    mem_ack_i = 0;
    d_req_i = 1; d_we_i = 1; d_addr_i = 32'h100; d_wdata_i = 32'hDEAD_BEEF; d_be_i = 4'b0011;
    tick();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, d_valid_o} !== {2'b11, 4'b0011, 32'h100, 32'hDEAD_BEEF, 1'b0}) begin
        n_bad++; $display("FAIL write_hold[%0d] got req%b we%b be%b a%h w%h v%b want 1 1 0011 100 deadbeef 0",
                          k, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, d_valid_o);
      end
      d_req_i = 0; d_we_i = $urandom_range(0, 1); d_addr_i = $urandom; d_wdata_i = $urandom; d_be_i = 4'($urandom);
      tick();
    end
    mem_ack_i = 1; mem_rdata_i = 32'h1234_5678;
    tick();
    mem_ack_i = 0;
    n_cmp++;
    if ({d_valid_o, mem_req_o} !== 2'b10 || d_rdata_o !== 32'h1234_5678) begin
      n_bad++; $display("FAIL write_done got %b %h want 10 12345678", {d_valid_o, mem_req_o}, d_rdata_o);
    end
  endtask

  task automatic test_starvation();
    logic [DW-1:0] rd, ia, da;
    do_reset();
    ia = $urandom; da = $urandom;
    if_req_i = 1; d_req_i = 1; d_we_i = 0; if_addr_i = ia; d_addr_i = da;
    tick();
    for (int k = 0; k < 15; k++) begin
      logic want_i;
      want_i = ((k % 5) == 4);
      n_cmp++;
      if ({if_gnt_o, d_gnt_o} !== {want_i, ~want_i} || mem_addr_o !== (want_i ? ia : da)) begin
        n_bad++; $display("FAIL starve_gnt[%0d] got %b a%h want %b a%h", k, {if_gnt_o, d_gnt_o}, mem_addr_o,
                          {want_i, ~want_i}, (want_i ? ia : da));
      end
      ia = $urandom; da = $urandom; if_addr_i = ia; d_addr_i = da;
      tick();
      n_cmp++;
      if ({if_gnt_o, d_gnt_o, if_valid_o, d_valid_o, mem_req_o} !== 5'b00001) begin
        n_bad++; $display("FAIL starve_busy[%0d] got %b want 00001", k, {if_gnt_o, d_gnt_o, if_valid_o, d_valid_o, mem_req_o});
      end
      rd = $urandom; mem_ack_i = 1; mem_rdata_i = rd;
      tick();
      mem_ack_i = 0;
      n_cmp++;
      if ({if_valid_o, d_valid_o} !== {want_i, ~want_i} || (want_i ? if_rdata_o : d_rdata_o) !== rd) begin
        n_bad++; $display("FAIL starve_valid[%0d] got %b i%h d%h want %b %h", k, {if_valid_o, d_valid_o},
                          if_rdata_o, d_rdata_o, {want_i, ~want_i}, rd);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_req_i = 1; d_addr_i = 32'h300;
    tick();
    d_req_i = 0;
    tick();
    tick();
    #2 rst = 0;
    #1;
    n_cmp++;
    if (mem_req_o !== 1'b0 || dut_vec !== '0) begin
      n_bad++; $display("FAIL rst_mid_async got req%b vec %h want 0", mem_req_o, dut_vec);
    end
    mem_ack_i = 1; mem_rdata_i = 32'h7777_7777;
    @(negedge clk);
    rst = 1;
    tick();
    n_cmp++;
    if ({d_valid_o, mem_req_o, d_gnt_o} !== 3'b000 || d_rdata_o !== '0) begin
      n_bad++; $display("FAIL rst_mid_novalid got %b %h want 000 0", {d_valid_o, mem_req_o, d_gnt_o}, d_rdata_o);
    end
    mem_ack_i = 0;
    d_req_i = 1; d_addr_i = 32'h304;
    tick();
    n_cmp++;
    if ({d_gnt_o, mem_req_o} !== 2'b11 || mem_addr_o !== 32'h304) begin
      n_bad++; $display("FAIL rst_mid_regrant got %b %h want 11 304", {d_gnt_o, mem_req_o}, mem_addr_o);
    end
    d_req_i = 0; mem_ack_i = 1; mem_rdata_i = 32'h0BAD_F00D;
    tick();
    mem_ack_i = 0;
    n_cmp++;
    if (d_valid_o !== 1'b1 || d_rdata_o !== 32'h0BAD_F00D) begin
      n_bad++; $display("FAIL rst_mid_complete got v%b d%h want 1 0badf00d", d_valid_o, d_rdata_o);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    if_req_i = 1; if_addr_i = 32'h70;
    tick();
    if_req_i = 0; mem_ack_i = 1; mem_rdata_i = 32'hCAFE_0001;
    tick();
    mem_ack_i = 0; mem_rdata_i = 32'h9999_9999;
    if_req_i = 1; if_addr_i = 32'h80;
    tick();
    if_req_i = 0;
`ifdef ARB_TIMEOUT_EN
    for (int k = 1; k < 16; k++) begin
      tick();
      n_cmp++;
      if ({if_valid_o, err_o, mem_req_o} !== 3'b001) begin
        n_bad++; $display("FAIL tmo_wait[%0d] got %b want 001", k, {if_valid_o, err_o, mem_req_o});
      end
    end
    tick();
    n_cmp++;
    if ({if_valid_o, err_o, mem_req_o} !== 3'b110 || if_rdata_o !== '0) begin
      n_bad++; $display("FAIL tmo_fire got %b d%h want 110 0", {if_valid_o, err_o, mem_req_o}, if_rdata_o);
    end
    d_req_i = 1; d_addr_i = 32'h90;
    tick();
    d_req_i = 0;
    n_cmp++;
    if ({if_valid_o, err_o, d_gnt_o} !== 3'b001 || mem_addr_o !== 32'h90) begin
      n_bad++; $display("FAIL tmo_after got %b a%h want 001 90", {if_valid_o, err_o, d_gnt_o}, mem_addr_o);
    end
`else
    for (int k = 1; k < 41; k++) begin
      tick();
      n_cmp++;
      if ({if_valid_o, err_o, mem_req_o} !== 3'b001 || if_rdata_o !== 32'hCAFE_0001) begin
        n_bad++; $display("FAIL notmo_wait[%0d] got %b d%h want 001 cafe0001", k, {if_valid_o, err_o, mem_req_o}, if_rdata_o);
      end
    end
    mem_ack_i = 1; mem_rdata_i = 32'h4444_0004;
    tick();
    mem_ack_i = 0;
    n_cmp++;
    if ({if_valid_o, err_o, mem_req_o} !== 3'b100 || if_rdata_o !== 32'h4444_0004) begin
      n_bad++; $display("FAIL notmo_done got %b d%h want 100 44440004", {if_valid_o, err_o, mem_req_o}, if_rdata_o);
    end
`endif
  endtask

  // Transaction-level rules: who wins, what is latched, when it completes.
  task automatic model_step();
    int win;
    e_if_gnt = 0; e_d_gnt = 0; e_if_valid = 0; e_d_valid = 0; e_err = 0;
    if (m_owner == 0) begin
      win = 0;
      if (if_req_i && d_req_i) win = (m_starve == SM) ? 1 : 2;
      else if (if_req_i)       win = 1;
      else if (d_req_i)        win = 2;
      if (win == 1) begin
        e_if_gnt = 1; e_mem_req = 1; e_mem_we = 0; e_mem_addr = if_addr_i;
        e_mem_wdata = '0; e_mem_be = 4'hF; m_starve = 0;
      end else if (win == 2) begin
        e_d_gnt = 1; e_mem_req = 1; e_mem_we = d_we_i; e_mem_addr = d_addr_i;
        e_mem_wdata = d_wdata_i; e_mem_be = d_be_i;
        if (if_req_i) m_starve = (m_starve + 1 > SM) ? SM : m_starve + 1;
      end
      m_owner = win;
      m_elapsed = 0;
    end else begin
      m_elapsed++;
      if (mem_ack_i) begin
        e_mem_req = 0;
        if (m_owner == 1) begin e_if_valid = 1; e_if_rdata = mem_rdata_i; end
        else              begin e_d_valid = 1;  e_d_rdata  = mem_rdata_i; end
        m_owner = 0;
      end
`ifdef ARB_TIMEOUT_EN
      else if (m_elapsed == TO) begin
        e_mem_req = 0; e_err = 1;
        if (m_owner == 1) begin e_if_valid = 1; e_if_rdata = '0; end
        else              begin e_d_valid = 1;  e_d_rdata  = '0; end
        m_owner = 0;
      end
`endif
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] want;
    do_reset();
    m_owner = 0; m_starve = 0; m_elapsed = 0;
    {e_if_gnt, e_d_gnt, e_if_valid, e_d_valid, e_mem_req, e_mem_we, e_err} = '0;
    e_if_rdata = '0; e_d_rdata = '0; e_mem_addr = '0; e_mem_wdata = '0; e_mem_be = '0;
    for (int c = 0; c < 500; c++) begin
      want = {e_if_gnt, e_d_gnt, e_if_valid, e_d_valid, e_if_rdata, e_d_rdata,
              e_mem_req, e_mem_we, e_mem_addr, e_mem_wdata, e_mem_be, e_err};
      n_cmp++;
      if (dut_vec !== want) begin
        n_bad++; $display("FAIL random[%0d] got %h want %h", c, dut_vec, want);
      end
      if_req_i = ($urandom_range(0, 2) != 0); if_addr_i = $urandom;
      d_req_i = ($urandom_range(0, 2) != 0); d_we_i = $urandom_range(0, 1);
      d_addr_i = $urandom; d_wdata_i = $urandom; d_be_i = 4'($urandom);
      mem_ack_i = ($urandom_range(0, 2) == 0); mem_rdata_i = $urandom;
      model_step();
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    rst = 0;
    clear_inputs();
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_write();
    test_starvation();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
